// File: rtl/data_mem_if.sv
// D_MEM bus between the RV32I core (master) and the data memory (slave).
interface data_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] D_MEM_addr;
   logic [WORD_WIDTH-1:0] D_MEM_dataIn;
   logic                  D_MEM_memRead;
   logic                  D_MEM_memWrite;
   logic [1:0]            D_MEM_memMode;
   logic [WORD_WIDTH-1:0] D_MEM_dataOut;
   logic                  ready;
   logic                  misalign_err;

   modport master (
      output D_MEM_addr, D_MEM_dataIn, D_MEM_memRead, D_MEM_memWrite, D_MEM_memMode,
      input  D_MEM_dataOut, ready, misalign_err
   );

   modport slave (
      input  D_MEM_addr, D_MEM_dataIn, D_MEM_memRead, D_MEM_memWrite, D_MEM_memMode,
      output D_MEM_dataOut, ready, misalign_err
   );
endinterface

// File: rtl/data_mem.sv
// Word-organised data RAM for the RV32I core: zero-fills itself after reset, then serves
// byte/half/word loads (registered, sign-extended) and stores. Option: D_MEM_MISALIGN_CHECK_EN.
module data_mem #(
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   data_mem_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            r_state;
   logic [IDX_W-1:0]      r_init_cnt;
   logic [WORD_WIDTH-1:0] r_mem [DEPTH];
   logic [WORD_WIDTH-1:0] r_dout;

   logic [IDX_W-1:0]      w_idx;
   logic                  w_run;
   logic                  w_is_half;
   logic                  w_is_byte;
   logic                  w_is_word;
   logic                  w_misalign;
   logic                  w_drop;
   logic                  w_st;
   logic                  w_ld;
   logic [1:0]            w_off;
   logic [3:0]            w_be;
   logic [WORD_WIDTH-1:0] w_wdata;
   logic [WORD_WIDTH-1:0] w_rd_word;
   logic [15:0]           w_half;
   logic [7:0]            w_byte;
   logic [WORD_WIDTH-1:0] w_ld_data;
   logic [WORD_WIDTH-1:0] w_ld_out;
   logic                  w_unused;

   // Upper address bits only alias; they carry no information here.
   assign w_unused = ^bus.D_MEM_addr[ADDR_WIDTH-1:IDX_W+2];

   assign w_idx      = bus.D_MEM_addr[IDX_W+1:2];
   assign w_run      = (r_state == ST_RUN);
   assign w_is_half  = (bus.D_MEM_memMode == 2'b01);
   assign w_is_byte  = (bus.D_MEM_memMode == 2'b10);
   assign w_is_word  = !w_is_half && !w_is_byte;
   assign w_misalign = (w_is_half && bus.D_MEM_addr[0]) ||
                       (w_is_word && (bus.D_MEM_addr[1:0] != 2'b00));

`ifdef D_MEM_MISALIGN_CHECK_EN
   assign w_drop = w_misalign;
`else
   assign w_drop = 1'b0;
`endif

   assign w_st = w_run && !rst && bus.D_MEM_memWrite && !w_drop;
   assign w_ld = w_run && !rst && bus.D_MEM_memRead;

   // Lane offset with offending low bits forced to zero (only matters when not dropped).
   always_comb begin
      w_off   = 2'b00;
      w_be    = 4'b1111;
      w_wdata = bus.D_MEM_dataIn;
      if (w_is_byte) begin
         w_off   = bus.D_MEM_addr[1:0];
         w_be    = 4'b0001 << bus.D_MEM_addr[1:0];
         w_wdata = {4{bus.D_MEM_dataIn[7:0]}};
      end else if (w_is_half) begin
         w_off   = {bus.D_MEM_addr[1], 1'b0};
         w_be    = bus.D_MEM_addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{bus.D_MEM_dataIn[15:0]}};
      end
   end

   assign w_rd_word = r_mem[w_idx];
   assign w_half    = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_byte = w_rd_word[7:0];
      case (w_off)
         2'b01:   w_byte = w_rd_word[15:8];
         2'b10:   w_byte = w_rd_word[23:16];
         2'b11:   w_byte = w_rd_word[31:24];
         default: w_byte = w_rd_word[7:0];
      endcase
   end

   always_comb begin
      w_ld_data = w_rd_word;
      if (w_is_byte)      w_ld_data = {{(WORD_WIDTH-8){w_byte[7]}}, w_byte};
      else if (w_is_half) w_ld_data = {{(WORD_WIDTH-16){w_half[15]}}, w_half};
   end

`ifdef D_MEM_MISALIGN_CHECK_EN
   assign w_ld_out = w_misalign ? '0 : w_ld_data;
`else
   assign w_ld_out = w_ld_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_dout     <= '0;
      end else if (!w_run) begin
         r_init_cnt <= r_init_cnt + IDX_W'(1);
         if (r_init_cnt == IDX_W'(DEPTH-1)) r_state <= ST_RUN;
      end else if (w_ld) begin
         r_dout <= w_ld_out;
      end
   end

   // Reads above use the pre-edge word, so a same-cycle load sees the old contents.
   always_ff @(posedge clk) begin
      if (!rst && !w_run) begin
         r_mem[r_init_cnt] <= '0;
      end else if (w_st) begin
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
   end

`ifdef D_MEM_MISALIGN_CHECK_EN
   logic r_misalign;
   always_ff @(posedge clk) begin
      if (rst)
         r_misalign <= 1'b0;
      else if (w_run && (bus.D_MEM_memRead || bus.D_MEM_memWrite) && w_misalign)
         r_misalign <= 1'b1;
   end
   assign bus.misalign_err = r_misalign;
`else
   assign bus.misalign_err = 1'b0;
`endif

   assign bus.D_MEM_dataOut = r_dout;
   assign bus.ready         = w_run;
endmodule
